muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Parametrised multi-cycle multiply/divide unit producing HI/LO results for MULT/MULTU/DIV/DIVU. It succeeds the single-cycle combinational multiplier: shift-add multiply and restoring divide run one bit per cycle, with a start/busy/done handshake. It sits beside the ALU in the execute stage; the controller stalls on busy and reads hi/lo after done.

Parameters:
WIDTH, 32, operand width in bits; hi/lo are WIDTH each; must be >= 4.
CW, 6, iteration counter width; must satisfy 2**CW > WIDTH.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-high
start  in  1  request; sampled only in IDLE
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  in  WIDTH  multiplicand / dividend
b  in  WIDTH  multiplier / divisor
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
hi  out  WIDTH  product upper half / remainder
lo  out  WIDTH  product lower half / quotient
div_by_zero  out  1  sticky: set by divide with b==0, cleared by next accepted start

Behaviour:
- One clock (clk); asynchronous active-high reset (rst): state=IDLE; counter, working registers, hi, lo = 0; busy=0, done=0, div_by_zero=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 at an edge = accept. Latch op, a, b; clear div_by_zero. Signed ops (MULT, DIV) latch operand magnitudes plus sign bits; unsigned ops latch raw values. Counter=WIDTH. Go to CALC.
- Accept with DIV/DIVU and b==0: go directly to DONE. Write hi=a (raw), lo=all ones; set div_by_zero. done is high the cycle after the accept edge.
- CALC, multiply: 2*WIDTH-bit shift-add, one multiplier bit per cycle.
- CALC, divide: restoring divide, one quotient bit per cycle.
- CALC: counter decrements each cycle; after WIDTH CALC cycles go to FIX.
- FIX, MULT: negate the 2*WIDTH product if the operand signs differ.
- FIX, DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- FIX, unsigned ops: pass through unchanged.
- FIX -> DONE edge: write hi/lo.
- Latency: done high in the cycle following edge WIDTH+2 after the accept edge (35 cycles for WIDTH=32).
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored; earliest next accept is the first IDLE edge.
- start in CALC/FIX/DONE: ignored; latched operands unchanged.
- hi/lo hold their value until the next completion. Mid-operation values never appear on hi/lo.
- Signed overflow DIV (most-negative / -1): lo=most-negative (wraps), hi=0, div_by_zero=0.
- Magnitude of most-negative is taken as unsigned 2**(WIDTH-1); the full 2*WIDTH multiply result is exact.
- a, b, op may change freely after the accept edge.
- rst asserted mid-operation: immediate return to IDLE with all reset values; no done pulse.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; busy rises next edge; done one cycle, 35 cycles after accept.
- MULT a=-3 b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1. MULT 0x80000000*0x80000000 -> hi=0x40000000 lo=0.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU 100/7 -> lo=14 hi=2. DIV 0x80000000/-1 -> lo=0x80000000 hi=0.
- DIVU a=100 b=0 -> done the cycle after accept; hi=0x64 lo=0xFFFFFFFF div_by_zero=1. Next MULTU start -> div_by_zero clears at accept.
- Start MULTU 6*7; during CALC pulse start with DIVU 9/3 -> ignored; result hi=0 lo=42; exactly one done.
- Start MULT; assert rst at cycle 10 -> busy=0, hi=lo=0, no done; after release, MULTU 2*3 -> lo=6.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a start/busy/done handshake and registered HI/LO.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              is_div_q;
    logic              sign_a_q;
    logic              sign_b_q;
    // Multiply: {upper partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [W2-1:0]     acc_q;
    // Multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0]  dvsr_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic              busy_q;
    logic              done_q;
    logic              dbz_q;

    logic              a_neg_s;
    logic              b_neg_s;
    logic [WIDTH-1:0]  a_mag_s;
    logic [WIDTH-1:0]  b_mag_s;
    logic              b_zero_s;
    logic [WIDTH:0]    mul_sum_s;
    logic [W2-1:0]     mul_next_s;
    logic [WIDTH:0]    div_trial_s;
    logic [WIDTH:0]    div_diff_s;
    logic [W2-1:0]     div_next_s;
    logic [W2-1:0]     calc_d;
    logic [W2-1:0]     prod_neg_s;
    logic [WIDTH-1:0]  fix_hi_d;
    logic [WIDTH-1:0]  fix_lo_d;

    // Operand conditioning at accept: signed ops use magnitudes (most-negative stays 2**(WIDTH-1) unsigned).
    always_comb begin
        a_neg_s  = op[0] & a[WIDTH-1];
        b_neg_s  = op[0] & b[WIDTH-1];
        b_zero_s = (b == {WIDTH{1'b0}});
        if (a_neg_s) begin
            a_mag_s = ~a + WIDTH'(1);
        end else begin
            a_mag_s = a;
        end
        if (b_neg_s) begin
            b_mag_s = ~b + WIDTH'(1);
        end else begin
            b_mag_s = b;
        end
    end

    // One iteration step: shift-add multiply or restoring divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[W2-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, dvsr_q} : {(WIDTH+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_q[WIDTH-1:1]};
        div_trial_s = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_s  = div_trial_s - {1'b0, dvsr_q};
        // Top bit of the difference set means the trial was smaller than the divisor.
        if (div_diff_s[WIDTH]) begin
            div_next_s = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        if (is_div_q) begin
            calc_d = div_next_s;
        end else begin
            calc_d = mul_next_s;
        end
    end

    // Sign fix-up: negate product or quotient on sign mismatch; remainder follows dividend sign.
    always_comb begin
        prod_neg_s = ~acc_q + W2'(1);
        fix_hi_d   = acc_q[W2-1:WIDTH];
        fix_lo_d   = acc_q[WIDTH-1:0];
        if (is_div_q) begin
            if (sign_a_q ^ sign_b_q) begin
                fix_lo_d = ~acc_q[WIDTH-1:0] + WIDTH'(1);
            end else begin
                fix_lo_d = acc_q[WIDTH-1:0];
            end
            if (sign_a_q) begin
                fix_hi_d = ~acc_q[W2-1:WIDTH] + WIDTH'(1);
            end else begin
                fix_hi_d = acc_q[W2-1:WIDTH];
            end
        end else begin
            if (sign_a_q ^ sign_b_q) begin
                {fix_hi_d, fix_lo_d} = prod_neg_s;
            end else begin
                {fix_hi_d, fix_lo_d} = acc_q;
            end
        end
    end

    // Control FSM with all datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= {W2{1'b0}};
            dvsr_q   <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        is_div_q <= op[1];
                        sign_a_q <= a_neg_s;
                        sign_b_q <= b_neg_s;
                        cnt_q    <= CW'(WIDTH);
                        busy_q   <= 1'b1;
                        dbz_q    <= op[1] & b_zero_s;
                        if (op[1] && b_zero_s) begin
                            // Divide by zero completes immediately with a fixed result.
                            hi_q    <= a;
                            lo_q    <= {WIDTH{1'b1}};
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            acc_q   <= {{WIDTH{1'b0}}, (op[1] ? a_mag_s : b_mag_s)};
                            dvsr_q  <= op[1] ? b_mag_s : a_mag_s;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt_q == {CW{1'b0}}) begin
                        state_q <= S_FIX;
                    end else begin
                        acc_q <= calc_d;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed test-plan ops plus a few
// model-checked random ops, results tracked through a scoreboard queue.
module tb_muldiv_seq;

    localparam int WIDTH = 32;
    localparam int CW    = 6;
    localparam int LAT   = WIDTH + 2;

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] l;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    res_t        sb_q[$];

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t mk(input logic [31:0] h, input logic [31:0] l, input logic z);
        res_t r;
        r.h = h;
        r.l = l;
        r.z = z;
        return r;
    endfunction

    // Reference arithmetic in 64 bits (truncating signed division, remainder follows dividend).
    function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t r;
        logic [63:0] p;
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] q;
        logic signed [63:0] m;
        r  = mk(32'd0, 32'd0, 1'b0);
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            2'b00: begin
                p = {32'd0, x} * {32'd0, y};
                r = mk(p[63:32], p[31:0], 1'b0);
            end
            2'b01: begin
                q = sx * sy;
                r = mk(q[63:32], q[31:0], 1'b0);
            end
            default: begin
                if (y == 32'd0) begin
                    r = mk(x, 32'hFFFF_FFFF, 1'b1);
                end else if (o == 2'b10) begin
                    r = mk(x % y, x / y, 1'b0);
                end else begin
                    q = sx / sy;
                    m = sx % sy;
                    r = mk(m[31:0], q[31:0], 1'b0);
                end
            end
        endcase
        return r;
    endfunction

    // Issue one op, follow it to done, and compare against the scoreboard entry.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input res_t exp_r, input int inj_at);
        res_t got_exp;
        int   k;
        int   lat_exp;
        bit   seen;
        lat_exp = exp_r.z ? 0 : LAT;
        sb_q.push_back(exp_r);
        @(negedge clk);
        check({tag, "_idle_busy"}, 64'(busy), 64'(1'b0));
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom_range(3, 0));
        a  = $urandom;
        b  = $urandom;
        k = 0;
        seen = 1'b0;
        while (!seen && k <= LAT + 20) begin
            @(negedge clk);
            if (k == 0) begin
                check({tag, "_busy_rise"}, 64'(busy), 64'(1'b1));
                check({tag, "_dbz_at_accept"}, 64'(div_by_zero), 64'(exp_r.z));
            end
            if (lat_exp > 0 && k == LAT / 2) begin
                check({tag, "_hold_hi"}, 64'(hi), 64'(prev_hi));
                check({tag, "_hold_lo"}, 64'(lo), 64'(prev_lo));
            end
            if (inj_at > 0 && k == inj_at) begin
                start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3;
            end
            if (inj_at > 0 && k == inj_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                k++;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'(1'b1));
        check({tag, "_latency"}, 64'(k), 64'(lat_exp));
        if (sb_q.size() > 0) begin
            got_exp = sb_q.pop_front();
            check({tag, "_hi"}, 64'(hi), 64'(got_exp.h));
            check({tag, "_lo"}, 64'(lo), 64'(got_exp.l));
            check({tag, "_dbz"}, 64'(div_by_zero), 64'(got_exp.z));
            prev_hi = got_exp.h;
            prev_lo = got_exp.l;
        end
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'(1'b0));
        check({tag, "_busy_fall"}, 64'(busy), 64'(1'b0));
    endtask

    // Directed sequence followed by random model-checked ops.
    initial begin
        int          n_done;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        prev_hi = 32'd0; prev_lo = 32'd0;
        #1;
        check("reset_busy", 64'(busy), 64'(1'b0));
        check("reset_done", 64'(done), 64'(1'b0));
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_dbz", 64'(div_by_zero), 64'(1'b0));
        @(negedge clk);
        rst = 1'b0;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0), 0);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, mk(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0), 0);
        run_op("mult_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, mk(32'h4000_0000, 32'h0, 1'b0), 0);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0), 0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0), 0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'h8000_0000, 1'b0), 0);
        run_op("divu_zero", 2'b10, 32'd100, 32'd0, mk(32'h64, 32'hFFFF_FFFF, 1'b1), 0);
        repeat (3) @(negedge clk);
        check("dbz_sticky", 64'(div_by_zero), 64'(1'b1));
        run_op("multu_ign", 2'b00, 32'd6, 32'd7, mk(32'd0, 32'd42, 1'b0), 5);
        n_done = 0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("ign_no_extra_done", 64'(n_done), 64'd0);

        // Reset in the middle of a MULT.
        @(negedge clk);
        op = 2'b01; a = 32'hFFFF_FFFD; b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_pre_busy", 64'(busy), 64'(1'b1));
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy), 64'(1'b0));
        check("rst_mid_done", 64'(done), 64'(1'b0));
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rst_no_done", 64'(n_done), 64'd0);
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        run_op("multu_2_3", 2'b00, 32'd2, 32'd3, mk(32'd0, 32'd6, 1'b0), 0);

        for (int i = 0; i < 6; i++) begin
            ro = 2'(i % 4);
            ra = $urandom;
            rb = $urandom;
            if (i >= 4) rb = {28'd0, rb[3:0]} | 32'd1;
            run_op("random", ro, ra, rb, model(ro, ra, rb), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
